// File: rtl/rc4_crack_core.sv
// RC4 decrypt-and-check engine: initialises and keys an external S RAM, decrypts
// the ciphertext ROM into the result RAM, and flags whether every byte is printable.
module rc4_crack_core #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [23:0]       secret_key,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [MSG_AW-1:0] d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren,
    output logic              success,
    output logic              failure
);

    localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT,
        ST_K_RD_I, ST_K_WT_I, ST_K_RD_J, ST_K_WT_J, ST_K_WR_I, ST_K_WR_J,
        ST_P_RD_I, ST_P_WT_I, ST_P_RD_J, ST_P_WT_J, ST_P_WR_I, ST_P_WR_J,
        ST_P_RD_T, ST_P_WT_T, ST_P_CHK,
        ST_FIN, ST_PASS, ST_FAIL
    } state_t;

    state_t            r_state;
    logic              r_run_prev;
    logic [23:0]       r_key;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_t;
    logic [1:0]        r_kidx;
    logic [MSG_AW-1:0] r_k;
    logic [7:0]        r_s_addr;
    logic [7:0]        r_s_wdata;
    logic              r_s_wren;
    logic [MSG_AW-1:0] r_rom_addr;
    logic [MSG_AW-1:0] r_d_addr;
    logic [7:0]        r_d_wdata;
    logic              r_d_wren;
    logic              r_success;
    logic              r_failure;

    logic [7:0] w_key_byte;
    logic [7:0] w_ksa_j;
    logic [7:0] w_prga_j;
    logic [7:0] w_i_next;
    logic [7:0] w_p;

    function automatic logic is_printable(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
    endfunction

    // Key byte K[i mod 3] selected by the rolling mod-3 counter.
    always_comb begin
        w_key_byte = 8'h00;
        case (r_kidx)
            2'd0:    w_key_byte = r_key[23:16];
            2'd1:    w_key_byte = r_key[15:8];
            2'd2:    w_key_byte = r_key[7:0];
            default: w_key_byte = 8'h00;
        endcase
    end

    assign w_ksa_j  = r_j + s_rdata + w_key_byte;
    assign w_prga_j = r_j + s_rdata;
    assign w_i_next = r_i + 8'd1;
    assign w_p      = s_rdata ^ rom_rdata;

    // Main sequencer; all memory strobes and flags leave this block registered.
    always_ff @(posedge clk) begin
        r_run_prev <= run;
        if (reset || !run) begin
            r_state    <= ST_IDLE;
            r_s_addr   <= 8'h00;
            r_s_wdata  <= 8'h00;
            r_s_wren   <= 1'b0;
            r_rom_addr <= '0;
            r_d_addr   <= '0;
            r_d_wdata  <= 8'h00;
            r_d_wren   <= 1'b0;
            r_success  <= 1'b0;
            r_failure  <= 1'b0;
            r_i        <= 8'h00;
            r_j        <= 8'h00;
            r_si       <= 8'h00;
            r_t        <= 8'h00;
            r_kidx     <= 2'd0;
            r_k        <= '0;
            if (reset) r_key <= 24'h000000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A run held high through reset must toggle before a new start.
                    if (!r_run_prev) begin
                        r_key     <= secret_key;
                        r_s_addr  <= 8'h00;
                        r_s_wdata <= 8'h00;
                        r_s_wren  <= 1'b1;
                        r_state   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (r_s_addr == 8'hFF) begin
                        r_s_wren <= 1'b0;
                        r_i      <= 8'h00;
                        r_j      <= 8'h00;
                        r_kidx   <= 2'd0;
                        r_state  <= ST_K_RD_I;
                    end else begin
                        r_s_addr  <= r_s_addr + 8'd1;
                        r_s_wdata <= r_s_addr + 8'd1;
                    end
                end
                ST_K_RD_I: begin
                    r_s_addr <= r_i;
                    r_s_wren <= 1'b0;
                    r_state  <= ST_K_WT_I;
                end
                ST_K_WT_I: r_state <= ST_K_RD_J;
                ST_K_RD_J: begin
                    r_si     <= s_rdata;
                    r_j      <= w_ksa_j;
                    r_s_addr <= w_ksa_j;
                    r_state  <= ST_K_WT_J;
                end
                ST_K_WT_J: r_state <= ST_K_WR_I;
                ST_K_WR_I: begin
                    r_s_addr  <= r_i;
                    r_s_wdata <= s_rdata;
                    r_s_wren  <= 1'b1;
                    r_state   <= ST_K_WR_J;
                end
                ST_K_WR_J: begin
                    r_s_addr  <= r_j;
                    r_s_wdata <= r_si;
                    r_s_wren  <= 1'b1;
                    r_i       <= w_i_next;
                    r_kidx    <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
                    if (r_i == 8'hFF) begin
                        r_j     <= 8'h00;
                        r_k     <= '0;
                        r_state <= ST_P_RD_I;
                    end else begin
                        r_state <= ST_K_RD_I;
                    end
                end
                ST_P_RD_I: begin
                    r_i        <= w_i_next;
                    r_s_addr   <= w_i_next;
                    r_s_wren   <= 1'b0;
                    r_rom_addr <= r_k;
                    r_d_wren   <= 1'b0;
                    r_state    <= ST_P_WT_I;
                end
                ST_P_WT_I: r_state <= ST_P_RD_J;
                ST_P_RD_J: begin
                    r_si     <= s_rdata;
                    r_j      <= w_prga_j;
                    r_s_addr <= w_prga_j;
                    r_state  <= ST_P_WT_J;
                end
                ST_P_WT_J: r_state <= ST_P_WR_I;
                ST_P_WR_I: begin
                    r_t       <= r_si + s_rdata;
                    r_s_addr  <= r_i;
                    r_s_wdata <= s_rdata;
                    r_s_wren  <= 1'b1;
                    r_state   <= ST_P_WR_J;
                end
                ST_P_WR_J: begin
                    r_s_addr  <= r_j;
                    r_s_wdata <= r_si;
                    r_s_wren  <= 1'b1;
                    r_state   <= ST_P_RD_T;
                end
                // Keystream read is issued only after both swap writes have landed.
                ST_P_RD_T: begin
                    r_s_addr <= r_t;
                    r_s_wren <= 1'b0;
                    r_state  <= ST_P_WT_T;
                end
                ST_P_WT_T: r_state <= ST_P_CHK;
                ST_P_CHK: begin
                    if (is_printable(w_p)) begin
                        r_d_addr  <= r_k;
                        r_d_wdata <= w_p;
                        r_d_wren  <= 1'b1;
                        if (r_k == LAST_K) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_k     <= r_k + MSG_AW'(1);
                            r_state <= ST_P_RD_I;
                        end
                    end else begin
                        r_failure <= 1'b1;
                        r_state   <= ST_FAIL;
                    end
                end
                ST_FIN: begin
                    r_d_wren  <= 1'b0;
                    r_success <= 1'b1;
                    r_state   <= ST_PASS;
                end
                ST_PASS: r_state <= ST_PASS;
                ST_FAIL: r_state <= ST_FAIL;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wren   = r_s_wren;
    assign rom_addr = r_rom_addr;
    assign d_addr   = r_d_addr;
    assign d_wdata  = r_d_wdata;
    assign d_wren   = r_d_wren;
    assign success  = r_success;
    assign failure  = r_failure;

endmodule

// File: tb/tb_rc4_crack_core.sv
// Scoreboard bench for rc4_crack_core: memories modelled here, expectations from a
// plain RC4 reference model, writes and flags checked by an independent monitor.
module tb_rc4_crack_core;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;
    localparam int BOUND   = 256 + 6*256 + 10*MSG_LEN + 8;

    logic              clk = 1'b0;
    logic              reset, run, d_clr;
    logic [23:0]       secret_key;
    logic [7:0]        s_addr, s_wdata, s_rdata, rom_rdata, d_wdata;
    logic              s_wren, d_wren, success, failure;
    logic [MSG_AW-1:0] rom_addr, d_addr;

    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [MSG_LEN];
    logic [7:0] d_mem   [MSG_LEN];
    logic [7:0] m_s     [256];
    logic [7:0] m_ks    [MSG_LEN];
    logic [7:0] pt      [MSG_LEN];

    logic [12:0] exp_wr[$];
    logic [1:0]  exp_flag[$];
    logic [1:0]  exp_final;
    int          exp_wr_total;
    int          wr_count = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_prev = 1'b0;

    always #5 clk = ~clk;

    rc4_crack_core #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .clk(clk), .reset(reset), .run(run), .secret_key(secret_key),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
        .success(success), .failure(failure)
    );

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wdata;
        s_rdata <= s_mem[s_addr];
    end

    always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

    always @(posedge clk) begin
        if (d_clr) begin
            for (int n = 0; n < MSG_LEN; n++) d_mem[n] <= 8'hEE;
        end else if (d_wren) begin
            d_mem[d_addr] <= d_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({s_addr, s_wdata, s_wren, rom_addr, d_addr, d_wdata, d_wren, success, failure});
    endfunction

    function automatic bit printable(input logic [7:0] c);
        return (c == 8'h20) || (c inside {[8'h61:8'h7A]});
    endfunction

    // Textbook RC4 on integer arrays: final S and the first MSG_LEN keystream bytes.
    task automatic ref_rc4(input logic [23:0] key);
        int S[256];
        int kb[3];
        int j, i, t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) S[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + S[n] + kb[n % 3]) % 256;
            t = S[n]; S[n] = S[j]; S[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + S[i]) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            m_ks[k] = 8'(S[(S[i] + S[j]) % 256]);
        end
        for (int n = 0; n < 256; n++) m_s[n] = 8'(S[n]);
    endtask

    task automatic set_fox();
        string s;
        s = "the quick brown fox jumps over t";
        for (int k = 0; k < MSG_LEN; k++) pt[k] = s[k];
    endtask

    task automatic set_random_pt();
        int r;
        for (int k = 0; k < MSG_LEN; k++) begin
            r = $urandom_range(0, 26);
            pt[k] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
        end
    endtask

    task automatic load_golden();
        for (int k = 0; k < MSG_LEN; k++) rom_mem[k] = pt[k] ^ m_ks[k];
    endtask

    // Expected writes stop at the first byte that decrypts to a non-printable value.
    task automatic predict();
        logic [7:0] p;
        bit bad;
        exp_wr.delete();
        exp_flag.delete();
        exp_wr_total = 0;
        bad = 1'b0;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (!bad) begin
                p = m_ks[k] ^ rom_mem[k];
                if (printable(p)) begin
                    exp_wr.push_back({5'(k), p});
                    exp_wr_total++;
                end else begin
                    bad = 1'b1;
                end
            end
        end
        exp_final = bad ? 2'b01 : 2'b10;
        exp_flag.push_back(exp_final);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string name, input logic [23:0] key, input bit check_s);
        int  base, cyc, bad;
        bit  got;
        predict();
        base = wr_count;
        d_clr = 1'b1;
        tick(1);
        d_clr = 1'b0;
        secret_key = key;
        run = 1'b1;
        tick(3);
        secret_key = 24'($urandom());
        cyc = 3;
        got = 1'b0;
        while (!got && cyc < BOUND + 4) begin
            @(negedge clk);
            cyc++;
            if (success || failure) got = 1'b1;
        end
        check({name, "_flag_in_bound"}, 64'(got), 64'd1);
        tick(3);
        check({name, "_flags_held"}, 64'({success, failure}), 64'(exp_final));
        check({name, "_write_count"}, 64'(wr_count - base), 64'(exp_wr_total));
        check({name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_flags_left"}, 64'(exp_flag.size()), 64'd0);
        bad = 0;
        for (int k = 0; k < MSG_LEN; k++)
            if (d_mem[k] !== ((k < exp_wr_total) ? pt[k] : 8'hEE)) bad++;
        check({name, "_result_ram_bad_bytes"}, 64'(bad), 64'd0);
        if (check_s) begin
            bad = 0;
            for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad++;
            check({name, "_s_ram_bad_bytes"}, 64'(bad), 64'd0);
        end
        run = 1'b0;
        tick(1);
        check({name, "_idle_after_run_low"}, all_outputs(), 64'd0);
        tick(1);
    endtask

    // Monitor: every result write and every flag rise is matched against the queues.
    initial begin
        logic [12:0] e;
        logic [1:0]  ef;
        forever begin
            @(negedge clk);
            if (d_wren) begin
                wr_count++;
                check("write_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("write_addr_data", 64'({d_addr, d_wdata}), 64'(e));
                end
            end
            if ((success || failure) && !mon_prev) begin
                check("flag_expected", 64'(exp_flag.size() > 0), 64'd1);
                if (exp_flag.size() > 0) begin
                    ef = exp_flag.pop_front();
                    check("flag_value", 64'({success, failure}), 64'(ef));
                end
            end
            mon_prev = success || failure;
        end
    end

    initial begin
        logic [63:0] acc;
        int          pos;
        logic [7:0]  badc [5];
        badc[0] = 8'h60; badc[1] = 8'h7B; badc[2] = 8'h1F; badc[3] = 8'h21; badc[4] = 8'h41;
        reset = 1'b1; run = 1'b0; secret_key = 24'h0; d_clr = 1'b0;
        for (int k = 0; k < MSG_LEN; k++) rom_mem[k] = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("reset_outputs", all_outputs(), 64'd0);

        ref_rc4(24'h000249);
        set_fox();
        load_golden();
        run_case("pass_000249", 24'h000249, 1'b1);

        rom_mem[0] = m_ks[0] ^ 8'h7B;
        run_case("early_fail", 24'h000249, 1'b0);

        load_golden();
        rom_mem[MSG_LEN-1] = m_ks[MSG_LEN-1] ^ 8'h60;
        run_case("last_fail", 24'h000249, 1'b0);

        // Abort in the middle of key scheduling, then restart with another key.
        load_golden();
        exp_wr.delete(); exp_flag.delete();
        secret_key = 24'h000249;
        run = 1'b1;
        tick(500);
        run = 1'b0;
        tick(1);
        acc = all_outputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = acc | 64'({success, failure, s_wren, d_wren});
        end
        check("abort_quiet", acc, 64'd0);
        secret_key = 24'h000001;
        tick(1);
        ref_rc4(24'h000001);
        set_random_pt();
        pt[0] = 8'h61; pt[1] = 8'h7A; pt[2] = 8'h20;
        load_golden();
        run_case("abort_key1", 24'h000001, 1'b1);

        // Synchronous reset in the middle of PRGA with run left high.
        ref_rc4(24'h000249);
        set_fox();
        load_golden();
        predict();
        secret_key = 24'h000249;
        run = 1'b1;
        tick(1900);
        reset = 1'b1;
        tick(1);
        check("sreset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;
        acc = 64'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = acc | all_outputs();
        end
        check("sreset_stays_idle", acc, 64'd0);
        tick(1);
        exp_wr.delete(); exp_flag.delete();
        run = 1'b0;
        tick(2);
        run_case("after_sreset", 24'h000249, 1'b1);

        ref_rc4(24'hFFFFFF);
        set_fox();
        load_golden();
        run_case("key_ffffff", 24'hFFFFFF, 1'b1);

        for (int r = 0; r < 3; r++) begin
            logic [23:0] key;
            bit          inj;
            key = 24'($urandom());
            ref_rc4(key);
            set_random_pt();
            load_golden();
            inj = ($urandom_range(0, 1) == 1);
            if (inj) begin
                pos = $urandom_range(0, MSG_LEN - 1);
                rom_mem[pos] = m_ks[pos] ^ badc[$urandom_range(0, 4)];
            end
            run_case($sformatf("random%0d", r), key, !inj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
